// File: rtl/tiny_soc_sig_gen.sv
// Signature generator: writes x1..xN register words, a value stream, then a stop/trap word.
// One registered word per cycle from the first edge after reset; no backpressure.
module tiny_soc_sig_gen #(
   parameter int unsigned NUM_INT_REGS  = 31,
   parameter int unsigned STREAM_LEN    = 16,
   parameter logic [63:0] VALUE_SEED    = 64'h0123_4567_89AB_CDEF,
   parameter logic [63:0] TAINT_SEED    = 64'h1,
   parameter bit          END_WITH_TRAP = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        mem_req_o,
   output logic [63:0] mem_addr_o,
   output logic [63:0] mem_wdata_o,
   output logic [7:0]  mem_strb_o,
   output logic        mem_we_o,
   output logic [63:0] mem_rdata_o,
   output logic        mem_req_o_t0,
   output logic [63:0] mem_addr_o_t0,
   output logic [63:0] mem_wdata_o_t0,
   output logic [7:0]  mem_strb_o_t0,
   output logic        mem_we_o_t0,
   output logic [63:0] mem_rdata_o_t0
);

   localparam int unsigned MAX_LEN = (NUM_INT_REGS > STREAM_LEN) ? NUM_INT_REGS : STREAM_LEN;
   localparam int unsigned CNT_W   = (MAX_LEN < 1) ? 1 : $clog2(MAX_LEN + 1);
   localparam logic [CNT_W-1:0] NUM_C = CNT_W'(NUM_INT_REGS);
   localparam logic [CNT_W-1:0] STR_C = CNT_W'(STREAM_LEN);
   localparam logic [63:0] ADDR_INT   = 64'h10;
   localparam logic [63:0] ADDR_STR   = 64'h20;
   localparam logic [63:0] ADDR_FINAL = END_WITH_TRAP ? 64'h8 : 64'h0;

   typedef enum logic [2:0] {IDLE_RST, DUMP_INT, DUMP_STREAM, FINAL, DONE} state_t;
   typedef enum logic [1:0] {K_NONE, K_INT, K_STR, K_FIN} kind_t;

   state_t           state;
   kind_t            kind;
   logic [CNT_W-1:0] cnt;
   logic [63:0]      val;
   logic [63:0]      tnt;
   logic [63:0]      val_nxt;
   logic [63:0]      tnt_nxt;

   // XOR with own rotation: result taint is the OR of both operand taints
   assign val_nxt = val ^ {val[62:0], val[63]};
   assign tnt_nxt = tnt | {tnt[62:0], tnt[63]};

   // What the next edge will present, decided from the current phase and word count
   always_comb begin
      kind = K_NONE;
      case (state)
         IDLE_RST, DUMP_INT: begin
            if (cnt < NUM_C)          kind = K_INT;
            else if (STREAM_LEN != 0) kind = K_STR;
            else                      kind = K_FIN;
         end
         DUMP_STREAM: kind = (cnt < STR_C) ? K_STR : K_FIN;
         default:     kind = K_NONE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= IDLE_RST;
         cnt            <= '0;
         val            <= VALUE_SEED;
         tnt            <= TAINT_SEED;
         mem_req_o      <= 1'b0;
         mem_we_o       <= 1'b0;
         mem_strb_o     <= '0;
         mem_addr_o     <= '0;
         mem_wdata_o    <= '0;
         mem_wdata_o_t0 <= '0;
      end else begin
         mem_req_o  <= (kind != K_NONE);
         mem_we_o   <= (kind != K_NONE);
         mem_strb_o <= (kind != K_NONE) ? 8'hFF : 8'h00;
         case (kind)
            K_INT: begin
               mem_addr_o     <= ADDR_INT;
               mem_wdata_o    <= val;
               mem_wdata_o_t0 <= tnt;
               val            <= val_nxt;
               tnt            <= tnt_nxt;
               cnt            <= cnt + 1'b1;
               state          <= DUMP_INT;
            end
            K_STR: begin
               mem_addr_o     <= ADDR_STR;
               mem_wdata_o    <= val;
               mem_wdata_o_t0 <= tnt;
               val            <= val_nxt;
               tnt            <= tnt_nxt;
               // counter restarts when crossing from the register dump
               cnt            <= (state == DUMP_STREAM) ? cnt + 1'b1 : CNT_W'(1);
               state          <= DUMP_STREAM;
            end
            K_FIN: begin
               mem_addr_o     <= ADDR_FINAL;
               mem_wdata_o    <= '0;
               mem_wdata_o_t0 <= '0;
               state          <= FINAL;
            end
            default: begin
               mem_addr_o     <= '0;
               mem_wdata_o    <= '0;
               mem_wdata_o_t0 <= '0;
               state          <= DONE;
            end
         endcase
      end
   end

   assign mem_rdata_o    = '0;
   assign mem_req_o_t0   = 1'b0;
   assign mem_addr_o_t0  = '0;
   assign mem_strb_o_t0  = '0;
   assign mem_we_o_t0    = 1'b0;
   assign mem_rdata_o_t0 = '0;

endmodule

// File: tb/tb_tiny_soc_sig_gen.sv
// Bench for tiny_soc_sig_gen: default, trap-ending and zero-taint instances share clock and reset.
module tb_tiny_soc_sig_gen;

   localparam int          NI    = 31;
   localparam int          NS    = 16;
   localparam logic [63:0] VSEED = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] TSEED = 64'h1;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [7:0]  strb;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      logic        req_t;
      logic        we_t;
      logic [7:0]  strb_t;
      logic [63:0] addr_t;
      logic [63:0] wdata_t;
      logic [63:0] rdata_t;
   } out_t;

   typedef struct {
      int          run;
      int          cyc;
      logic        req;
      logic [63:0] addr;
      logic        chk_wd;
      logic [63:0] wdata;
      logic [63:0] wt;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_w   [3];
   logic [63:0] addr_w  [3];
   logic [63:0] wdata_w [3];
   logic [7:0]  strb_w  [3];
   logic        we_w    [3];
   logic [63:0] rdata_w [3];
   logic        req_tw  [3];
   logic [63:0] addr_tw [3];
   logic [63:0] wdata_tw[3];
   logic [7:0]  strb_tw [3];
   logic        we_tw   [3];
   logic [63:0] rdata_tw[3];
   out_t        o       [3];

   // instance 0: defaults, 1: ends with trap, 2: zero taint seed
   for (genvar g = 0; g < 3; g++) begin : g_dut
      tiny_soc_sig_gen #(
         .NUM_INT_REGS (NI),
         .STREAM_LEN   (NS),
         .VALUE_SEED   (VSEED),
         .TAINT_SEED   ((g == 2) ? 64'h0 : TSEED),
         .END_WITH_TRAP(g == 1)
      ) dut (
         .clk_i         (clk),
         .rst_i         (rst),
         .mem_req_o     (req_w[g]),
         .mem_addr_o    (addr_w[g]),
         .mem_wdata_o   (wdata_w[g]),
         .mem_strb_o    (strb_w[g]),
         .mem_we_o      (we_w[g]),
         .mem_rdata_o   (rdata_w[g]),
         .mem_req_o_t0  (req_tw[g]),
         .mem_addr_o_t0 (addr_tw[g]),
         .mem_wdata_o_t0(wdata_tw[g]),
         .mem_strb_o_t0 (strb_tw[g]),
         .mem_we_o_t0   (we_tw[g]),
         .mem_rdata_o_t0(rdata_tw[g])
      );
      assign o[g] = {req_w[g], we_w[g], strb_w[g], addr_w[g], wdata_w[g], rdata_w[g],
                     req_tw[g], we_tw[g], strb_tw[g], addr_tw[g], wdata_tw[g], rdata_tw[g]};
   end

   int   errors = 0;
   int   checks = 0;
   int   run    = 0;
   int   cyc    = 0;
   out_t q_m[$];
   out_t q_t[$];
   out_t q_n[$];
   out_t hist[3][64];

   logic [63:0] mv;
   logic [63:0] mt;
   int          midx;

   function automatic logic [63:0] rotl1(input logic [63:0] v);
      return {v[62:0], v[63]};
   endfunction

   task automatic check_out(input string name, input out_t got, input out_t want, input int c);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, c, got, want);
      end
   endtask

   task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // Predict the word the next edge presents, queue it, clock, then compare
   task automatic step(input logic r);
      out_t e;
      out_t et;
      out_t en;
      logic fin;
      e   = '0;
      fin = 1'b0;
      if (r) begin
         midx = 0;
         mv   = VSEED;
         mt   = TSEED;
      end else begin
         if (midx < NI + NS) begin
            e.req     = 1'b1;
            e.we      = 1'b1;
            e.strb    = 8'hFF;
            e.addr    = (midx < NI) ? 64'h10 : 64'h20;
            e.wdata   = mv;
            e.wdata_t = mt;
            mv        = mv ^ rotl1(mv);
            mt        = mt | rotl1(mt);
         end else if (midx == NI + NS) begin
            e.req  = 1'b1;
            e.we   = 1'b1;
            e.strb = 8'hFF;
            fin    = 1'b1;
         end
         if (midx <= NI + NS) midx++;
      end
      et = e;
      if (fin) et.addr = 64'h8;
      en = e;
      en.wdata_t = '0;
      q_m.push_back(e);
      q_t.push_back(et);
      q_n.push_back(en);

      rst = r;
      @(posedge clk);
      #1;
      cyc = r ? 0 : cyc + 1;
      check_out("main", o[0], q_m.pop_front(), cyc);
      check_out("trap", o[1], q_t.pop_front(), cyc);
      check_out("notaint", o[2], q_n.pop_front(), cyc);
      if (!r && cyc < 64) hist[run][cyc] = o[0];
   endtask

   vec_t tbl[12];
   int   n10;
   int   n20;
   int   nfin;

   initial begin
      tbl[0]  = '{0, 1,  1'b1, 64'h10, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h1};
      tbl[1]  = '{0, 2,  1'b1, 64'h10, 1'b1, 64'h0365_CFA8_9AFC_5631, 64'h3};
      tbl[2]  = '{0, 31, 1'b1, 64'h10, 1'b0, 64'h0, 64'h7FFF_FFFF};
      tbl[3]  = '{0, 32, 1'b1, 64'h20, 1'b0, 64'h0, 64'hFFFF_FFFF};
      tbl[4]  = '{0, 47, 1'b1, 64'h20, 1'b0, 64'h0, 64'h7FFF_FFFF_FFFF};
      tbl[5]  = '{0, 48, 1'b1, 64'h0,  1'b1, 64'h0, 64'h0};
      tbl[6]  = '{0, 49, 1'b0, 64'h0,  1'b1, 64'h0, 64'h0};
      tbl[7]  = '{0, 60, 1'b0, 64'h0,  1'b1, 64'h0, 64'h0};
      tbl[8]  = '{2, 1,  1'b1, 64'h10, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h1};
      tbl[9]  = '{2, 2,  1'b1, 64'h10, 1'b1, 64'h0365_CFA8_9AFC_5631, 64'h3};
      tbl[10] = '{2, 48, 1'b1, 64'h0,  1'b1, 64'h0, 64'h0};
      tbl[11] = '{2, 49, 1'b0, 64'h0,  1'b1, 64'h0, 64'h0};

      run = 0;
      repeat (3) step(1'b1);
      repeat (60) step(1'b0);

      // interrupted pass: reset lands on the 20th cycle and holds for two
      run = 1;
      repeat (2) step(1'b1);
      repeat (19) step(1'b0);
      repeat (2) step(1'b1);

      run = 2;
      repeat (60) step(1'b0);

      for (int i = 0; i < 12; i++) begin
         out_t h;
         h = hist[tbl[i].run][tbl[i].cyc];
         check_val($sformatf("tbl%0d_req", i), {63'b0, h.req}, {63'b0, tbl[i].req});
         check_val($sformatf("tbl%0d_addr", i), h.addr, tbl[i].addr);
         check_val($sformatf("tbl%0d_wt", i), h.wdata_t, tbl[i].wt);
         if (tbl[i].chk_wd) check_val($sformatf("tbl%0d_wdata", i), h.wdata, tbl[i].wdata);
      end

      n10 = 0;
      n20 = 0;
      nfin = 0;
      for (int c = 1; c <= 60; c++) begin
         if (hist[0][c].req && hist[0][c].addr == 64'h10) n10++;
         if (hist[0][c].req && hist[0][c].addr == 64'h20) n20++;
         if (hist[0][c].req && hist[0][c].addr == 64'h0)  nfin++;
      end
      check_val("count_int_writes", 64'(n10), 64'd31);
      check_val("count_stream_writes", 64'(n20), 64'd16);
      check_val("count_final_writes", 64'(nfin), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
